// File: rtl/alu_defs_pkg.sv
// Shared constants for the ALU front end: bus widths, enable codes and debounce states.
// Optional feature macro used by this slice: BOTONES_AUTOREPEAT_EN.
package alu_defs;

  localparam int unsigned CANT_SWITCHES = 6;
  localparam int unsigned CANT_BOTONES  = 4;
  localparam int unsigned CANT_LEDS     = 8;

  localparam logic [3:0] ENA_OP1       = 4'b0001;
  localparam logic [3:0] ENA_OPERACION = 4'b0010;
  localparam logic [3:0] ENA_OP2       = 4'b0100;

  typedef enum logic {
    ESTABLE  = 1'b0,
    CONTANDO = 1'b1
  } deb_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One button: 2-flop synchroniser, stability counter and debounced level.
// With BOTONES_AUTOREPEAT_EN defined, also raises o_repite every 8*CNT_MAX cycles while held.
module debounce_bit #(
  parameter int unsigned CNT_MAX   = 1000000,
  parameter int unsigned CNT_WIDTH = 20
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_boton,
  output logic o_estado,
  output logic o_repite
);
  import alu_defs::*;

  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(CNT_MAX - 1);

  logic                 sync1, sync2;
  deb_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 estado_q, estado_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      state_q  <= ESTABLE;
      cnt_q    <= '0;
      estado_q <= 1'b0;
    end else begin
      sync1    <= i_boton;
      sync2    <= sync1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      estado_q <= estado_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    estado_d = estado_q;
    unique case (state_q)
      ESTABLE: begin
        cnt_d = '0;
        if (sync2 != estado_q) begin
          state_d = CONTANDO;
          cnt_d   = CNT_WIDTH'(1);
        end
      end
      CONTANDO: begin
        if (sync2 == estado_q) begin
          cnt_d   = '0;
          state_d = ESTABLE;
        end else if (cnt_q >= CNT_TERM) begin
          estado_d = sync2;
          cnt_d    = '0;
          state_d  = ESTABLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ESTABLE;
      end
    endcase
  end

  assign o_estado = estado_q;

`ifdef BOTONES_AUTOREPEAT_EN
  localparam int unsigned          REP_WIDTH = CNT_WIDTH + 3;
  localparam logic [REP_WIDTH-1:0] REP_TERM  = REP_WIDTH'(8 * CNT_MAX - 1);

  logic [REP_WIDTH-1:0] rep_q;

  // Phase 0 coincides with the accepted press, so repeats land 8*CNT_MAX after the first pulse.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rep_q <= '0;
    end else if (!estado_q || rep_q == REP_TERM) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_q + REP_WIDTH'(1);
    end
  end

  assign o_repite = estado_q && (rep_q == '0);
`else
  assign o_repite = 1'b0;
`endif

endmodule

// File: rtl/debounce_botones.sv
// Synchronises switches, debounces buttons and issues one-hot press pulses with a switch snapshot.
// Optional auto-repeat of held buttons is enabled by defining BOTONES_AUTOREPEAT_EN.
module debounce_botones #(
  parameter int unsigned CANT_SWITCHES = alu_defs::CANT_SWITCHES,
  parameter int unsigned CANT_BOTONES  = alu_defs::CANT_BOTONES,
  parameter int unsigned CNT_MAX       = 1000000,
  parameter int unsigned CNT_WIDTH     = 20
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [CANT_SWITCHES-1:0] i_switch,
  input  logic [CANT_BOTONES-1:0]  i_boton,
  output logic [CANT_SWITCHES-1:0] o_switch,
  output logic [CANT_BOTONES-1:0]  o_enable,
  output logic [CANT_BOTONES-1:0]  o_estado
);

  logic [CANT_SWITCHES-1:0] sw_sync1, sw_sync2;
  logic [CANT_BOTONES-1:0]  estado, estado_prev, repite;
  logic [CANT_BOTONES-1:0]  candidato, grant;

  for (genvar g = 0; g < CANT_BOTONES; g++) begin : g_boton
    debounce_bit #(
      .CNT_MAX   (CNT_MAX),
      .CNT_WIDTH (CNT_WIDTH)
    ) u_debounce_bit (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_boton  (i_boton[g]),
      .o_estado (estado[g]),
      .o_repite (repite[g])
    );
  end

  // Lowest-index candidate wins; losers are dropped rather than queued.
  always_comb begin
    candidato = (estado & ~estado_prev) | repite;
    grant     = candidato & (~candidato + CANT_BOTONES'(1));
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sw_sync1    <= '0;
      sw_sync2    <= '0;
      estado_prev <= '0;
      o_enable    <= '0;
      o_switch    <= '0;
    end else begin
      sw_sync1    <= i_switch;
      sw_sync2    <= sw_sync1;
      estado_prev <= estado;
      o_enable    <= grant;
      if (|grant) begin
        o_switch <= sw_sync2;
      end
    end
  end

  assign o_estado = estado;

endmodule

// File: tb/tb_debounce_botones.sv
// Directed bench for debounce_botones with CNT_MAX = 16; logs every pulse and checks timing/value.
module tb_debounce_botones;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] i_switch;
  logic [3:0] i_boton;
  logic [5:0] o_switch;
  logic [3:0] o_enable;
  logic [3:0] o_estado;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int base;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [5:0] sw;
  } pulse_t;

  pulse_t pulses[$];

  debounce_botones #(
    .CANT_SWITCHES (6),
    .CANT_BOTONES  (4),
    .CNT_MAX       (16),
    .CNT_WIDTH     (5)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst_n),
    .i_switch (i_switch),
    .i_boton  (i_boton),
    .o_switch (o_switch),
    .o_enable (o_enable),
    .o_estado (o_estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (o_enable !== 4'b0000) begin
      pulses.push_back('{cyc: cyc, en: o_enable, sw: o_switch});
      chk("onehot", 32'($onehot(o_enable)), 32'd1);
    end
  end

  // Expect exactly one pulse of value en at base+19 carrying switch snapshot sw.
  task automatic chk_single(input string tag, input logic [3:0] en, input logic [5:0] sw);
    chk({tag, "_count"}, 32'(pulses.size()), 32'd1);
    if (pulses.size() >= 1) begin
      chk({tag, "_cycle"}, 32'(pulses[0].cyc), 32'(base + 19));
      chk({tag, "_enable"}, 32'(pulses[0].en), 32'(en));
      chk({tag, "_switch"}, 32'(pulses[0].sw), 32'(sw));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    i_switch = '0;
    i_boton  = '0;

    // Reset held while inputs toggle
    for (int i = 0; i < 8; i++) begin
      i_switch = 6'($urandom);
      i_boton  = 4'($urandom);
      @(negedge clk);
      chk("rst_enable", 32'(o_enable), 32'd0);
      chk("rst_switch", 32'(o_switch), 32'd0);
      chk("rst_estado", 32'(o_estado), 32'd0);
    end
    step(1);
    i_switch = '0;
    i_boton  = '0;
    step(2);
    rst_n = 1'b1;
    pulses.delete();
    step(100);
    chk("idle_pulses", 32'(pulses.size()), 32'd0);
    chk("idle_estado", 32'(o_estado), 32'd0);
    chk("idle_switch", 32'(o_switch), 32'd0);

    // Clean press of button 0
    pulses.delete();
    i_switch = 6'b000101;
    i_boton  = 4'b0001;
    base     = cyc;
    step(25);
    chk("clean_estado_held", 32'(o_estado), 32'h1);
    step(15);
    i_boton = 4'b0000;
    step(40);
    chk_single("clean", 4'b0001, 6'b000101);
    chk("clean_estado_rel", 32'(o_estado), 32'h0);

    // Bouncing button 1, then stable high
    pulses.delete();
    i_switch = 6'b101010;
    for (int i = 0; i < 12; i++) begin
      i_boton[1] = (i % 2 == 0);
      step(5);
    end
    i_boton[1] = 1'b1;
    base       = cyc;
    step(40);
    chk_single("bounce", 4'b0010, 6'b101010);
    i_boton = 4'b0000;
    step(40);

    // Simultaneous press of buttons 1 and 2
    pulses.delete();
    i_switch = 6'b110011;
    i_boton  = 4'b0110;
    base     = cyc;
    step(40);
    chk_single("simul", 4'b0010, 6'b110011);
    chk("simul_estado", 32'(o_estado), 32'h6);
    i_boton = 4'b0000;
    step(40);
    chk("simul_pulses_after", 32'(pulses.size()), 32'd1);

    // Reset asserted mid-count on button 2
    pulses.delete();
    i_switch = 6'b011110;
    i_boton  = 4'b0100;
    step(10);
    rst_n = 1'b0;
    step(3);
    chk("midrst_enable", 32'(o_enable), 32'd0);
    chk("midrst_switch", 32'(o_switch), 32'd0);
    chk("midrst_estado", 32'(o_estado), 32'd0);
    rst_n = 1'b1;
    base  = cyc;
    step(40);
    chk_single("midrst", 4'b0100, 6'b011110);
    i_boton = 4'b0000;
    step(40);

    // Long hold of button 0: auto-repeat when enabled, single pulse otherwise
    pulses.delete();
    i_switch = 6'b111000;
    i_boton  = 4'b0001;
    base     = cyc;
    step(400);
    i_boton = 4'b0000;
    step(60);
`ifdef BOTONES_AUTOREPEAT_EN
    chk("hold_count", 32'(pulses.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < pulses.size()) begin
        chk("hold_cycle", 32'(pulses[i].cyc), 32'(base + 19 + 128 * i));
        chk("hold_enable", 32'(pulses[i].en), 32'h1);
      end
    end
`else
    chk_single("hold", 4'b0001, 6'b111000);
`endif
    chk("hold_estado_rel", 32'(o_estado), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
